// File: rtl/day10_line_parser.sv
// Byte-stream parser for day-10 machine lines: "[lights] (btn)... {jolt}\n" -> one record per line.
// Working registers build the line; output registers load only on entry to EMIT.
module day10_line_parser #(
    parameter int MAX_NUM_LIGHTS    = 10,
    parameter int MAX_NUM_BUTTONS   = 13,
    parameter int MAX_NUM_LIGHTS_W  = (MAX_NUM_LIGHTS  <= 1) ? 1 : $clog2(MAX_NUM_LIGHTS + 1),
    parameter int MAX_NUM_BUTTONS_W = (MAX_NUM_BUTTONS <= 1) ? 1 : $clog2(MAX_NUM_BUTTONS + 1)
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [7:0]                                 in_data,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [MAX_NUM_LIGHTS_W-1:0]                num_lights,
    output logic [MAX_NUM_BUTTONS_W-1:0]               num_buttons,
    output logic [MAX_NUM_BUTTONS*MAX_NUM_LIGHTS-1:0]  buttons,
    output logic [MAX_NUM_LIGHTS-1:0]                  target_lights_arrangement,
    output logic                                       parse_error
);
    localparam int LW = MAX_NUM_LIGHTS_W;
    localparam int BW = MAX_NUM_BUTTONS_W;

    localparam logic [7:0] CH_LBRK = 8'h5B, CH_RBRK = 8'h5D, CH_DOT   = 8'h2E, CH_HASH  = 8'h23;
    localparam logic [7:0] CH_LPAR = 8'h28, CH_RPAR = 8'h29, CH_LBRC  = 8'h7B, CH_RBRC  = 8'h7D;
    localparam logic [7:0] CH_COMA = 8'h2C, CH_SPC  = 8'h20, CH_LF    = 8'h0A, CH_CR    = 8'h0D;

    typedef enum logic [2:0] {
        S_IDLE, S_LIGHTS, S_SEP, S_BTN, S_JOLT, S_EOL, S_EMIT, S_ERR
    } state_t;

    state_t                                        state_q, state_d;
    logic [LW-1:0]                                 light_cnt_q, light_cnt_d;
    logic [BW-1:0]                                 btn_cnt_q, btn_cnt_d;
    logic [MAX_NUM_LIGHTS-1:0]                     target_w_q, target_w_d;
    logic [MAX_NUM_BUTTONS-1:0][MAX_NUM_LIGHTS-1:0] masks_w_q, masks_w_d;
    logic [7:0]                                    idx_q, idx_d;
    logic                                          have_digit_q, have_digit_d;

    logic                                          in_ready_q, in_ready_d;
    logic                                          out_valid_q, out_valid_d;
    logic                                          parse_error_q, parse_error_d;
    logic [LW-1:0]                                 num_lights_q, num_lights_d;
    logic [BW-1:0]                                 num_buttons_q, num_buttons_d;
    logic [MAX_NUM_BUTTONS-1:0][MAX_NUM_LIGHTS-1:0] buttons_q, buttons_d;
    logic [MAX_NUM_LIGHTS-1:0]                     target_q, target_d;

    logic        accept;
    logic        is_digit;
    logic        err;
    logic [11:0] idx_sum;

    assign accept   = in_valid && in_ready_q;
    assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
    assign idx_sum  = 12'(idx_q) * 12'd10 + 12'(in_data[3:0]);

    always_comb begin
        state_d       = state_q;
        light_cnt_d   = light_cnt_q;
        btn_cnt_d     = btn_cnt_q;
        target_w_d    = target_w_q;
        masks_w_d     = masks_w_q;
        idx_d         = idx_q;
        have_digit_d  = have_digit_q;
        out_valid_d   = out_valid_q;
        num_lights_d  = num_lights_q;
        num_buttons_d = num_buttons_q;
        buttons_d     = buttons_q;
        target_d      = target_q;
        parse_error_d = 1'b0;
        err           = 1'b0;

        if (accept && in_data != CH_CR) begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_data == CH_LBRK) begin
                        state_d      = S_LIGHTS;
                        light_cnt_d  = '0;
                        btn_cnt_d    = '0;
                        target_w_d   = '0;
                        masks_w_d    = '0;
                        idx_d        = '0;
                        have_digit_d = 1'b0;
                    end else if (in_data != CH_LF && in_data != CH_SPC) begin
                        err = 1'b1;
                    end
                end
                S_LIGHTS: begin
                    if (in_data == CH_DOT || in_data == CH_HASH) begin
                        if (light_cnt_q == LW'(MAX_NUM_LIGHTS)) begin
                            err = 1'b1;
                        end else begin
                            for (int i = 0; i < MAX_NUM_LIGHTS; i++)
                                if (light_cnt_q == LW'(i)) target_w_d[i] = (in_data == CH_HASH);
                            light_cnt_d = light_cnt_q + LW'(1);
                        end
                    end else if (in_data == CH_RBRK && light_cnt_q != '0) begin
                        state_d = S_SEP;
                    end else begin
                        err = 1'b1;
                    end
                end
                S_SEP: begin
                    if (in_data == CH_LPAR) begin
                        if (btn_cnt_q == BW'(MAX_NUM_BUTTONS)) begin
                            err = 1'b1;
                        end else begin
                            state_d      = S_BTN;
                            idx_d        = '0;
                            have_digit_d = 1'b0;
                        end
                    end else if (in_data == CH_LBRC) begin
                        state_d = S_JOLT;
                    end else if (in_data != CH_SPC) begin
                        err = 1'b1;
                    end
                end
                S_BTN: begin
                    if (is_digit) begin
                        idx_d        = (idx_sum > 12'd255) ? 8'hFF : idx_sum[7:0];
                        have_digit_d = 1'b1;
                    end else if (in_data == CH_COMA || in_data == CH_RPAR) begin
                        if (!have_digit_q || int'(idx_q) >= int'(light_cnt_q)) begin
                            err = 1'b1;
                        end else begin
                            for (int b = 0; b < MAX_NUM_BUTTONS; b++)
                                for (int i = 0; i < MAX_NUM_LIGHTS; i++)
                                    if (btn_cnt_q == BW'(b) && idx_q == 8'(i)) masks_w_d[b][i] = 1'b1;
                            idx_d        = '0;
                            have_digit_d = 1'b0;
                            if (in_data == CH_RPAR) begin
                                btn_cnt_d = btn_cnt_q + BW'(1);
                                state_d   = S_SEP;
                            end
                        end
                    end else begin
                        err = 1'b1;
                    end
                end
                S_JOLT: begin
                    if (in_data == CH_RBRC) state_d = S_EOL;
                    else if (!is_digit && in_data != CH_COMA) err = 1'b1;
                end
                S_EOL: begin
                    if (in_data == CH_LF) state_d = S_EMIT;
                    else if (in_data != CH_SPC) err = 1'b1;
                end
                S_ERR: begin
                    if (in_data == CH_LF) state_d = S_IDLE;
                end
                default: ;
            endcase
        end

        // A bad '\n' already ends the line, so there is nothing left to discard.
        if (err) begin
            parse_error_d = 1'b1;
            state_d       = (in_data == CH_LF) ? S_IDLE : S_ERR;
        end

        if (state_q == S_EMIT && out_ready) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
        end

        if (state_d == S_EMIT && state_q != S_EMIT) begin
            out_valid_d   = 1'b1;
            num_lights_d  = light_cnt_q;
            num_buttons_d = btn_cnt_q;
            buttons_d     = masks_w_q;
            target_d      = target_w_q;
        end

        in_ready_d = (state_d != S_EMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            light_cnt_q   <= '0;
            btn_cnt_q     <= '0;
            target_w_q    <= '0;
            masks_w_q     <= '0;
            idx_q         <= '0;
            have_digit_q  <= 1'b0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            parse_error_q <= 1'b0;
            num_lights_q  <= '0;
            num_buttons_q <= '0;
            buttons_q     <= '0;
            target_q      <= '0;
        end else begin
            state_q       <= state_d;
            light_cnt_q   <= light_cnt_d;
            btn_cnt_q     <= btn_cnt_d;
            target_w_q    <= target_w_d;
            masks_w_q     <= masks_w_d;
            idx_q         <= idx_d;
            have_digit_q  <= have_digit_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            parse_error_q <= parse_error_d;
            num_lights_q  <= num_lights_d;
            num_buttons_q <= num_buttons_d;
            buttons_q     <= buttons_d;
            target_q      <= target_d;
        end
    end

    assign in_ready                  = in_ready_q;
    assign out_valid                 = out_valid_q;
    assign parse_error               = parse_error_q;
    assign num_lights                = num_lights_q;
    assign num_buttons               = num_buttons_q;
    assign buttons                   = buttons_q;
    assign target_lights_arrangement = target_q;

endmodule
